// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of the async FIFO write port.
// One requester owns the port for up to MAX_BURST words, then the grant
// rotates. Back-pressure is taken from the FIFO full/almost_full flags, and
// the FIFO-side write enable and data are registered.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic                          fifo_wr_enb,
  output logic [DATA_WIDTH-1:0]         fifo_input_data,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full
);

  localparam int                   CNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  state_t                 state, state_nxt;
  logic [ID_WIDTH-1:0]    owner, owner_nxt;
  logic [ID_WIDTH-1:0]    rr_last, rr_last_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   wr_enb_nxt;
  logic [DATA_WIDTH-1:0]  wr_data_nxt;

  logic                   space;
  logic                   own_req;
  logic [DATA_WIDTH-1:0]  own_word;
  logic                   xfer;

  // First requester with req set, searching upward from last+1 with wrap.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                  input logic [ID_WIDTH-1:0] last);
    logic [ID_WIDTH-1:0] sel;
    logic                found;
    int                  idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && r[idx]) begin
        sel   = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // A write issued last cycle still lands, so almost_full already means no room.
  assign space = !fifo_full && !(fifo_almost_full && fifo_wr_enb);

  // Select the current owner's request bit and word.
  always_comb begin
    own_req  = 1'b0;
    own_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_WIDTH'(i)) begin
        own_req  = req[i];
        own_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Owner status outputs; everything reads zero while idle.
  always_comb begin
    busy     = (state == BURST);
    grant    = '0;
    grant_id = '0;
    if (state == BURST) begin
      grant_id = owner;
      for (int i = 0; i < NUM_REQ; i++) begin
        grant[i] = (owner == ID_WIDTH'(i));
      end
    end
  end

  // Next-state, accept handshake and next FIFO write values.
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    rr_last_nxt = rr_last;
    cnt_nxt     = cnt;
    wr_enb_nxt  = 1'b0;
    wr_data_nxt = fifo_input_data;
    ready       = '0;
    xfer        = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_nxt = rr_pick(req, rr_last);
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner == ID_WIDTH'(i)) begin
            ready[i] = space;
          end
        end
        xfer = own_req && space;
        if (xfer) begin
          wr_enb_nxt  = 1'b1;
          wr_data_nxt = own_word;
          cnt_nxt     = cnt + 1'b1;
        end
        // A stall with req still held keeps the grant; only a full burst
        // or the owner dropping req hands the port on.
        if ((xfer && (cnt == CNT_LAST)) || !own_req) begin
          state_nxt   = IDLE;
          rr_last_nxt = owner;
          cnt_nxt     = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst context: owner, rotation pointer and word count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner   <= '0;
      rr_last <= LAST_INIT;
      cnt     <= '0;
    end else begin
      owner   <= owner_nxt;
      rr_last <= rr_last_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Registered FIFO write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_wr_enb     <= 1'b0;
      fifo_input_data <= '0;
    end else begin
      fifo_wr_enb     <= wr_enb_nxt;
      fifo_input_data <= wr_data_nxt;
    end
  end

endmodule
